// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 binary32 divider: one quotient bit per clock via restoring
// division, round-to-nearest-even, denormals flushed to zero, valid/ready handshakes.
module fp_div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [4:0]        count;
  logic [25:0]       rem;
  logic [25:0]       quo;
  logic [23:0]       mant_b;
  logic              sign;
  logic signed [9:0] exp_q;

  // Operand decode, only consumed on the acceptance edge
  logic [7:0]        ea, eb;
  logic              a_zero, b_zero, any_special, sign_in;
  logic signed [9:0] exp_in;

  assign ea          = a[30:23];
  assign eb          = b[30:23];
  assign a_zero      = (ea == 8'd0);
  assign b_zero      = (eb == 8'd0);
  assign any_special = (ea == 8'hFF) || (eb == 8'hFF);
  assign sign_in     = a[31] ^ b[31];
  assign exp_in      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // One restoring-division step; the remainder after subtraction is below mant_b,
  // so its top bit can be dropped before the shift.
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [25:0] rem_next;

  assign rem_ge   = (rem >= {2'b00, mant_b});
  assign rem_sub  = rem_ge ? 25'(rem - {2'b00, mant_b}) : rem[24:0];
  assign rem_next = {rem_sub, 1'b0};

  // Normalise, round and range-check the finished quotient
  logic [22:0]       mant_n, mant_r;
  logic              guard, sticky, inc, carry;
  logic [23:0]       rounded;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0]       norm_result;
  logic              norm_ovf, norm_unf;

  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    mant_n      = quo[23:1];
    guard       = quo[0];
    sticky      = (rem != 26'd0);
    exp_n       = exp_q - 10'sd1;
    if (quo[25]) begin
      mant_n = quo[24:2];
      guard  = quo[1];
      sticky = quo[0] | (rem != 26'd0);
      exp_n  = exp_q;
    end
    inc         = guard && (sticky || mant_n[0]);
    rounded     = {1'b0, mant_n} + {23'd0, inc};
    carry       = rounded[23];
    mant_r      = carry ? 23'd0 : rounded[22:0];
    exp_r       = exp_n + $signed({9'd0, carry});
    norm_ovf    = 1'b0;
    norm_unf    = 1'b0;
    norm_result = {sign, exp_r[7:0], mant_r};
    if (exp_r >= 10'sd255) begin
      norm_ovf    = 1'b1;
      norm_result = {sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      norm_unf    = 1'b1;
      norm_result = {sign, 31'd0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 5'd0;
      rem         <= 26'd0;
      quo         <= 26'd0;
      mant_b      <= 24'd0;
      sign        <= 1'b0;
      exp_q       <= 10'sd0;
      result      <= 32'd0;
      exception   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= sign_in;
            if (any_special || (a_zero && b_zero)) begin
              result      <= {sign_in, 31'd0};
              exception   <= 1'b1;
              overflow    <= 1'b0;
              underflow   <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= DONE;
            end else if (b_zero) begin
              result      <= {sign_in, 8'hFF, 23'd0};
              exception   <= 1'b0;
              overflow    <= 1'b0;
              underflow   <= 1'b0;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else if (a_zero) begin
              result      <= {sign_in, 31'd0};
              exception   <= 1'b0;
              overflow    <= 1'b0;
              underflow   <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= DONE;
            end else begin
              rem    <= {3'b001, a[22:0]};
              mant_b <= {1'b1, b[22:0]};
              exp_q  <= exp_in;
              quo    <= 26'd0;
              count  <= 5'd0;
              state  <= DIV;
            end
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= {quo[24:0], rem_ge};
          count <= count + 5'd1;
          if (count == 5'd25) state <= NORM;
        end
        NORM: begin
          result      <= norm_result;
          exception   <= 1'b0;
          overflow    <= norm_ovf;
          underflow   <= norm_unf;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: hand-computed quotients, special cases,
// range limits, output stall and mid-division reset abort.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        exception, overflow, underflow, div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero)
  );

  // flags packed as {exception, overflow, underflow, div_by_zero}
  function automatic logic [3:0] flags_now();
    return {exception, overflow, underflow, div_by_zero};
  endfunction

  // Present one operand pair, then count edges after the accept edge until out_valid.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                       output logic rdy, output int lat,
                       output logic [31:0] r, output logic [3:0] f);
    @(negedge clk);
    rdy = in_ready;
    a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    f = flags_now();
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [31:0] aa, input logic [31:0] bb,
                               input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
    logic rdy; int lat; logic [31:0] r; logic [3:0] f;
    do_op(aa, bb, rdy, lat, r, f);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL %s in_ready got=%b want=1", name, rdy); end
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
    total++;
    if (r !== exp_r) begin bad++; $display("FAIL %s result got=%h want=%h", name, r, exp_r); end
    total++;
    if (f !== exp_f) begin bad++; $display("FAIL %s flags got=%b want=%b", name, f, exp_f); end
    consume();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready_during got=%b want=0", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL reset result got=%h want=0", result); end
    total++;
    if (flags_now() !== 4'b0000) begin bad++; $display("FAIL reset flags got=%b want=0000", flags_now()); end
  endtask

  task automatic test_normal();
    run_and_check("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    run_and_check("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27);
    run_and_check("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 27);
    run_and_check("one_by_two",  32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 27);
  endtask

  task automatic test_special();
    run_and_check("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 0);
    run_and_check("zero_by_zero", 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000, 0);
    run_and_check("inf_by_one", 32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 0);
    run_and_check("one_by_negnan", 32'h3F800000, 32'hFFC00000, 32'h80000000, 4'b1000, 0);
    run_and_check("zero_by_five", 32'h00000000, 32'h40A00000, 32'h00000000, 4'b0000, 0);
    run_and_check("denorm_by_one", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0);
  endtask

  task automatic test_range();
    run_and_check("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100, 27);
    run_and_check("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0010, 27);
  endtask

  task automatic test_stall();
    logic rdy; int lat; logic [31:0] r; logic [3:0] f;
    do_op(32'h3F800000, 32'h40400000, rdy, lat, r, f);
    total++;
    if (r !== 32'h3EAAAAAB) begin bad++; $display("FAIL stall first_result got=%h want=3eaaaaab", r); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (result !== 32'h3EAAAAAB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall hold%0d result=%h out_valid=%b in_ready=%b want 3eaaaaab/1/0",
                 i, result, out_valid, in_ready);
      end
    end
    consume();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall in_ready_after got=%b want=1", in_ready); end
    run_and_check("after_stall", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
  endtask

  task automatic test_reset_abort();
    int seen;
    // leave a nonzero result registered so the reset clear is observable
    run_and_check("pre_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (result !== 32'd0 || flags_now() !== 4'b0000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort outputs result=%h flags=%b out_valid=%b in_ready=%b want all 0",
               result, flags_now(), out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL abort in_ready got=%b want=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort spurious_out_valid got=%0d want=0", seen); end
    run_and_check("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_stall();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
